// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: one-edge simple ops, WIDTH-edge shift-add MUL.
// Define SEQ_ALU_DIV_EN to build op 111 as restoring DIV; otherwise it behaves as PASSB.
module seq_alu #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ITER
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, z_q, z_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]   ex_sum;
    logic [WIDTH-1:0] ex_res;
    logic             ex_c;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             it_c;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   rem;
    logic             q_bit;
`endif

    function automatic logic is_iter(input logic [2:0] o);
`ifdef SEQ_ALU_DIV_EN
        return o[2:1] == 2'b11;
`else
        return o == 3'b110;
`endif
    endfunction

    always_comb begin
        ex_sum = {1'b0, a_q} + {1'b0, b_q};
        ex_res = b_q;
        ex_c   = 1'b0;
        case (op_q)
            3'b000: {ex_c, ex_res} = ex_sum;
            3'b001: begin
                ex_res = a_q - b_q;
                ex_c   = a_q < b_q;
            end
            3'b010: ex_res = a_q & b_q;
            3'b011: ex_res = a_q | b_q;
            3'b100: ex_res = a_q ^ b_q;
            default: ex_res = b_q;
        endcase
    end

    // hi:lo holds partial product (MUL) or remainder:dividend (DIV)
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        it_hi   = mul_sum[WIDTH:1];
        it_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
        it_c    = |mul_sum[WIDTH:1];
`ifdef SEQ_ALU_DIV_EN
        rem   = {hi_q, lo_q[WIDTH-1]};
        q_bit = rem >= {1'b0, b_q};
        if (q_bit) rem = rem - {1'b0, b_q};
        if (op_q[0]) begin
            it_hi = rem[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], q_bit};
            it_c  = b_q == '0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    op_d   = op;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = b;
`ifdef SEQ_ALU_DIV_EN
                    if (op[0]) lo_d = a;
`endif
                    state_d = is_iter(op) ? ITER : EXEC;
                end
            end
            EXEC: begin
                result_d = ex_res;
                c_d      = ex_c;
                z_d      = ex_res == '0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            ITER: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = it_lo;
                    c_d      = it_c;
                    z_d      = it_lo == '0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign c_flag = c_q;
    assign z_flag = z_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: cycle-level reference model plus directed and random ops.
// Follows SEQ_ALU_DIV_EN the same way as the design.
module tb_seq_alu;

    localparam int W = 12;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         c_flag, z_flag, busy, done;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .result(result), .c_flag(c_flag),
        .z_flag(z_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: operation outcome from plain arithmetic
    function automatic logic [W:0] ref_op(input logic [2:0] o,
                                          input int x, input int y);
        int r;
        logic c;
        r = y;
        c = 1'b0;
        case (o)
            3'd0: begin r = x + y; c = r > MASK; end
            3'd1: begin r = x - y; c = x < y; end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd6: begin r = x * y; c = (r >> W) != 0; end
`ifdef SEQ_ALU_DIV_EN
            3'd7: begin
                if (y == 0) begin r = MASK; c = 1'b1; end
                else r = x / y;
            end
`endif
            default: r = y;
        endcase
        return {c, W'(r & MASK)};
    endfunction

    function automatic int ref_lat(input logic [2:0] o);
`ifdef SEQ_ALU_DIV_EN
        if (o == 3'd7) return W;
`endif
        return (o == 3'd6) ? W : 1;
    endfunction

    logic [W-1:0] m_res;
    logic         m_c, m_z, m_busy, m_done;
    logic [W:0]   m_pend;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res  <= '0;
            m_c    <= 1'b0;
            m_z    <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_res  <= m_pend[W-1:0];
                    m_c    <= m_pend[W];
                    m_z    <= m_pend[W-1:0] == '0;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_pend <= ref_op(op, int'(a), int'(b));
                m_left <= ref_lat(op);
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("result", result, m_res);
        chk("c_flag", c_flag, m_c);
        chk("z_flag", z_flag, m_z);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    end

    // Caller sits at a negedge; acceptance happens on the following posedge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input int lat, input logic [W-1:0] r, input logic c);
        int n;
        issue(o, x, y);
        wait_done(n);
        chk({name, "_lat"}, n, lat);
        chk({name, "_res"}, result, r);
        chk({name, "_c"}, c_flag, c);
        chk({name, "_z"}, z_flag, r == '0);
    endtask

    initial begin
        int n;
        logic [2:0] o;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("add", 3'd0, 12, 23, 1, 35, 0);
        run("add_wrap", 3'd0, 12'hFFF, 12'h001, 1, 12'h000, 1);
        run("sub", 3'd1, 5, 7, 1, 12'hFFE, 1);
        run("and", 3'd2, 12'hF0F, 12'h3C3, 1, 12'h303, 0);
        run("mul", 3'd6, 23, 12, 12, 12'h114, 0);
        run("mul_ovf", 3'd6, 12'h100, 12'h010, 12, 12'h000, 1);

        // start held during MUL is ignored, then accepted right after done
        issue(3'd6, 3, 5);
        start = 1'b1; op = 3'd0; a = 1; b = 2;
        wait_done(n);
        chk("busy_ign_lat", n, 12);
        chk("busy_ign_res", result, 15);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("b2b_lat", n, 1);
        chk("b2b_res", result, 3);

        // reset in the middle of a MUL
        issue(3'd6, 23, 12);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_res", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 3'd0, 4, 5, 1, 9, 0);

`ifdef SEQ_ALU_DIV_EN
        run("div", 3'd7, 100, 7, 12, 14, 0);
        run("div0", 3'd7, 55, 0, 12, 12'hFFF, 1);
`else
        run("op7", 3'd7, 3, 9, 1, 9, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom);
            issue(o, W'($urandom), W'($urandom));
            wait_done(n);
            chk("rnd_lat", n, ref_lat(o));
            if ($urandom_range(3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
